handshake_fifo: RTL

// - Synchronous circular FIFO with valid/ready handshake on both sides.
// - Upstream elastic buffer: absorbs bursts and feeds a spill cell or pipeline stage downstream.
// - ready_o depends only on internal state, never on ready_i, so no combinational path crosses the block.
// - flush_i drops all in-flight entries, for pipeline squash on branch mispredict or exception.

---
 rtl/handshake_fifo.sv | 106 ++++++++++
 1 files changed

// File: rtl/handshake_fifo.sv
// handshake_fifo: circular FIFO with valid/ready handshakes on both sides.
// ready_o is derived only from the registered occupancy, so ready_i never
// reaches ready_o combinationally. flush_i empties the FIFO next cycle and
// takes priority over push and pop. Memory contents survive a flush.
// Optional feature: define HANDSHAKE_FIFO_BYPASS_EN for zero-latency
// fall-through while the FIFO is empty. The default build has no bypass.
module handshake_fifo #(
  parameter type         DATA_T = logic,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       flush_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  DATA_T                      data_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output DATA_T                      data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  DATA_T         mem_q [DEPTH];
  DATA_T         mem_d [DEPTH];

  logic push;
  logic pop;
  logic empty;
  logic full;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Handshake outputs and the accepted push/pop for this cycle
  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == CW'(DEPTH));
    ready_o = ~full;
    count_o = count_q;
    pop     = ~empty & ready_i;
`ifdef HANDSHAKE_FIFO_BYPASS_EN
    // While empty the input falls through; a word taken directly downstream
    // is never written, so count stays at zero.
    valid_o = ~flush_i & (~empty | valid_i);
    data_o  = empty ? data_i : mem_q[head_q];
    push    = valid_i & ~full & ~(empty & ready_i);
`else
    valid_o = ~empty;
    data_o  = mem_q[head_q];
    push    = valid_i & ~full;
`endif
  end

  // Next pointer, occupancy and memory state; flush overrides push and pop
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    mem_d   = mem_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[tail_q] = data_i;
        tail_d        = wrap_inc(tail_q);
      end
      if (pop) begin
        head_d = wrap_inc(head_q);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with asynchronous active-low reset clearing all entries
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule
